// File: rtl/cpu_pkg.sv
// Shared definitions for the execution control unit: opcodes, ALU codes,
// cu_state codes, FSM encoding and the instruction layout.
package cpu_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  localparam logic [1:0] CU_IDLE = 2'b00;
  localparam logic [1:0] CU_BUSY = 2'b01;
  localparam logic [1:0] CU_MEM  = 2'b10;
  localparam logic [1:0] CU_DONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_DONE,
    ST_HALTED
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_JMP,
    CLS_JZ,
    CLS_LOAD,
    CLS_STORE,
    CLS_HALT,
    CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational opcode decode: instruction class, ALU operation and
// operand-B select for the execution control unit.
module exec_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output cls_e       cls,
  output alu_op_e    alu_op,
  output logic       alu_src_imm
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    cls         = CLS_ILLEGAL;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    case (opcode)
      OP_NOP:   cls = CLS_NOP;
      OP_ADD:   cls = CLS_ALU;
      OP_SUB:   begin cls = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:    begin cls = CLS_ALU; alu_op = ALU_OR;  end
      OP_XOR:   begin cls = CLS_ALU; alu_op = ALU_XOR; end
      OP_ADDI:  begin cls = CLS_ALU; alu_src_imm = 1'b1; end
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      OP_JMP:   cls = CLS_JMP;
      OP_JZ:    cls = CLS_JZ;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execution control unit: sequences IDLE/READ/EXEC/MEM/WB/DONE/
// HALTED and decodes register-file, ALU, memory and PC strobes from state.
module exec_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ack,
  output logic [1:0]  cu_state,
  output logic [1:0]  rf_raddr_a,
  output logic [1:0]  rf_raddr_b,
  output logic [1:0]  rf_waddr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [7:0]  imm,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_load,
  output logic        halted,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  instr_t           instr_q, instr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_timeout_q, err_timeout_d;

  cls_e    cls;
  alu_op_e dec_alu_op;
  logic    dec_src_imm;

  exec_decode u_decode (
    .opcode      (instr_q.opcode),
    .cls         (cls),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        instr_d = instr_t'(instr);
        state_d = ST_READ;
      end
      ST_READ: begin
        case (cls)
          CLS_ALU, CLS_JMP, CLS_JZ: state_d = ST_EXEC;
          CLS_LOAD, CLS_STORE: begin
            state_d    = ST_MEM;
            wait_cnt_d = '0;
          end
          CLS_HALT: state_d = ST_HALTED;
          default:  state_d = ST_DONE;
        endcase
      end
      ST_EXEC: state_d = (cls == CLS_JMP || cls == CLS_JZ) ? ST_DONE : ST_WB;
      ST_MEM: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = (cls == CLS_LOAD) ? ST_WB : ST_DONE;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d       = ST_DONE;
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_WB:     state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking for all state so every register updates together.
      state_q       <= state_d;
      instr_q       <= instr_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    cu_state    = CU_IDLE;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    err_illegal = 1'b0;
    unique case (state_q)
      ST_IDLE: cu_state = CU_IDLE;
      ST_READ: begin
        cu_state    = CU_BUSY;
        err_illegal = (cls == CLS_ILLEGAL);
      end
      ST_EXEC: begin
        cu_state = CU_BUSY;
        pc_load  = (cls == CLS_JMP) || (cls == CLS_JZ && zero_flag);
      end
      ST_MEM: begin
        cu_state = CU_MEM;
        mem_req  = 1'b1;
        mem_we   = (cls == CLS_STORE);
      end
      ST_WB: begin
        cu_state = CU_BUSY;
        rf_we    = 1'b1;
        wb_sel   = (cls == CLS_LOAD);
      end
      ST_DONE: cu_state = CU_DONE;
      ST_HALTED: begin
        cu_state = CU_BUSY;
        halted   = 1'b1;
      end
      default: cu_state = CU_IDLE;
    endcase
  end

  assign rf_raddr_a  = instr_q.rd;
  assign rf_raddr_b  = instr_q.rs;
  assign rf_waddr    = instr_q.rd;
  assign imm         = instr_q.imm;
  assign alu_op      = dec_alu_op;
  assign alu_src_imm = dec_src_imm;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: one task per scenario with hand-computed
// expected values; outputs sampled 1ns after the rising edge.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, zero_flag, mem_ack;
  logic [15:0] instr;
  logic [1:0]  cu_state, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, wb_sel, alu_src_imm, mem_req, mem_we, pc_load;
  logic        halted, err_illegal, err_timeout;
  logic [2:0]  alu_op;
  logic [7:0]  imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .zero_flag   (zero_flag),
    .mem_ack     (mem_ack),
    .cu_state    (cu_state),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .pc_load     (pc_load),
    .halted      (halted),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with start for one IDLE cycle; returns in READ.
  task automatic issue(input logic [15:0] i);
    start = 1'b1;
    instr = i;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; instr = '0; zero_flag = 1'b0; mem_ack = 1'b0;
    #12;
    checks++; if (cu_state !== 2'b00) begin errors++; $display("FAIL reset_cu_state got %b exp 00", cu_state); end
    checks++; if ({rf_we, wb_sel, mem_req, mem_we, pc_load, halted, err_illegal, err_timeout} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes got %b exp 00000000",
                         {rf_we, wb_sel, mem_req, mem_we, pc_load, halted, err_illegal, err_timeout}); end
    checks++; if ({imm, rf_waddr, rf_raddr_b} !== 12'h000) begin errors++; $display("FAIL reset_latched got %h exp 000", {imm, rf_waddr, rf_raddr_b}); end
    @(negedge clk) reset = 1'b0;
    step();
    checks++; if (cu_state !== 2'b00) begin errors++; $display("FAIL reset_idle_hold got %b exp 00", cu_state); end
  endtask

  task automatic test_add();
    issue(16'h1600);
    checks++; if (cu_state !== 2'b01) begin errors++; $display("FAIL add_read cu_state got %b exp 01", cu_state); end
    step();
    checks++; if (alu_op !== 3'b000 || alu_src_imm !== 1'b0) begin errors++; $display("FAIL add_exec alu_op/src got %b/%b exp 000/0", alu_op, alu_src_imm); end
    checks++; if (rf_raddr_a !== 2'b01 || rf_raddr_b !== 2'b10 || rf_we !== 1'b0) begin
      errors++; $display("FAIL add_exec raddr_a/raddr_b/rf_we got %b/%b/%b exp 01/10/0", rf_raddr_a, rf_raddr_b, rf_we); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 2'b01 || wb_sel !== 1'b0) begin
      errors++; $display("FAIL add_wb rf_we/waddr/wb_sel got %b/%b/%b exp 1/01/0", rf_we, rf_waddr, wb_sel); end
    step();
    checks++; if (cu_state !== 2'b11 || rf_we !== 1'b0) begin errors++; $display("FAIL add_done_at_4 cu_state/rf_we got %b/%b exp 11/0", cu_state, rf_we); end
    step();
    checks++; if (cu_state !== 2'b00) begin errors++; $display("FAIL add_back_idle got %b exp 00", cu_state); end
  endtask

  task automatic test_alu_ops();
    logic [15:0] ins [6] = '{16'h1600, 16'h2600, 16'h3600, 16'h4600, 16'h5600, 16'h6605};
    logic [2:0]  ops [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic        src [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(ins[i]);
      step();
      checks++; if (alu_op !== ops[i] || alu_src_imm !== src[i]) begin
        errors++; $display("FAIL alu_op[%0d] op/src got %b/%b exp %b/%b", i, alu_op, alu_src_imm, ops[i], src[i]); end
      step(); step();
      checks++; if (cu_state !== 2'b11) begin errors++; $display("FAIL alu_done[%0d] got %b exp 11", i, cu_state); end
      step();
    end
  endtask

  task automatic test_load();
    issue(16'h7442);
    step();
    checks++; if (cu_state !== 2'b10 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL load_mem1 cu/req/we got %b/%b/%b exp 10/1/0", cu_state, mem_req, mem_we); end
    checks++; if (imm !== 8'h42) begin errors++; $display("FAIL load_imm got %h exp 42", imm); end
    step();
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL load_mem3 mem_req got %b exp 1", mem_req); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if (cu_state !== 2'b01 || rf_we !== 1'b1 || wb_sel !== 1'b1 || mem_req !== 1'b0 || rf_waddr !== 2'b01) begin
      errors++; $display("FAIL load_wb cu/rf_we/wb_sel/req/waddr got %b/%b/%b/%b/%b exp 01/1/1/0/01",
                         cu_state, rf_we, wb_sel, mem_req, rf_waddr); end
    step();
    checks++; if (cu_state !== 2'b11) begin errors++; $display("FAIL load_done_at_6 got %b exp 11", cu_state); end
    step();
  endtask

  task automatic test_store_timeout();
    int cyc = 1, req = 0, we = 0, rfwe = 0, tout = 0, tout_cyc = -1, done_cyc = -1;
    issue(16'h8123);
    while (done_cyc < 0 && cyc < 40) begin
      step(); cyc++;
      if (mem_req) req++;
      if (mem_req && mem_we) we++;
      if (rf_we) rfwe++;
      if (err_timeout) begin tout++; tout_cyc = cyc; end
      if (cu_state == 2'b11) done_cyc = cyc;
    end
    checks++; if (req != 15 || we != 15) begin errors++; $display("FAIL store_to req/we cycles got %0d/%0d exp 15/15", req, we); end
    checks++; if (tout != 1 || tout_cyc != 17) begin errors++; $display("FAIL store_to pulses/cycle got %0d/%0d exp 1/17", tout, tout_cyc); end
    checks++; if (done_cyc != 17 || rfwe != 0) begin errors++; $display("FAIL store_to done/rf_we got %0d/%0d exp 17/0", done_cyc, rfwe); end
    step();
    checks++; if (cu_state !== 2'b00 || err_timeout !== 1'b0) begin errors++; $display("FAIL store_to_idle cu/tout got %b/%b exp 00/0", cu_state, err_timeout); end
  endtask

  task automatic test_timeout_boundary();
    int cyc = 1, req = 0, tout = 0, wb_cyc = -1, done_cyc = -1;
    logic wbs = 1'b0;
    issue(16'h7442);
    while (done_cyc < 0 && cyc < 40) begin
      step(); cyc++;
      mem_ack = 1'b0;
      if (mem_req) req++;
      if (rf_we) begin wb_cyc = cyc; wbs = wb_sel; end
      if (err_timeout) tout++;
      if (cu_state == 2'b11) done_cyc = cyc;
      if (mem_req && req == 15) mem_ack = 1'b1;
    end
    checks++; if (req != 15 || tout != 0) begin errors++; $display("FAIL to_boundary req/tout got %0d/%0d exp 15/0", req, tout); end
    checks++; if (wb_cyc != 17 || wbs !== 1'b1 || done_cyc != 18) begin
      errors++; $display("FAIL to_boundary wb/wb_sel/done got %0d/%b/%0d exp 17/1/18", wb_cyc, wbs, done_cyc); end
    step();
  endtask

  task automatic test_jumps();
    zero_flag = 1'b1;
    issue(16'hA010);
    step();
    checks++; if (pc_load !== 1'b1 || imm !== 8'h10) begin errors++; $display("FAIL jz_taken pc_load/imm got %b/%h exp 1/10", pc_load, imm); end
    step();
    checks++; if (cu_state !== 2'b11 || pc_load !== 1'b0) begin errors++; $display("FAIL jz_taken_done cu/pc_load got %b/%b exp 11/0", cu_state, pc_load); end
    step();
    zero_flag = 1'b0;
    issue(16'hA010);
    step();
    checks++; if (pc_load !== 1'b0 || cu_state !== 2'b01) begin errors++; $display("FAIL jz_not_taken pc_load/cu got %b/%b exp 0/01", pc_load, cu_state); end
    step();
    checks++; if (cu_state !== 2'b11) begin errors++; $display("FAIL jz_nt_done got %b exp 11", cu_state); end
    step();
    issue(16'h9055);
    step();
    checks++; if (pc_load !== 1'b1 || imm !== 8'h55 || rf_we !== 1'b0) begin
      errors++; $display("FAIL jmp pc_load/imm/rf_we got %b/%h/%b exp 1/55/0", pc_load, imm, rf_we); end
    step();
    checks++; if (cu_state !== 2'b11) begin errors++; $display("FAIL jmp_done got %b exp 11", cu_state); end
    step();
  endtask

  task automatic test_illegal();
    issue(16'hC000);
    checks++; if (err_illegal !== 1'b1 || cu_state !== 2'b01) begin errors++; $display("FAIL illegal_read err/cu got %b/%b exp 1/01", err_illegal, cu_state); end
    step();
    checks++; if (err_illegal !== 1'b0 || cu_state !== 2'b11 || rf_we !== 1'b0) begin
      errors++; $display("FAIL illegal_done err/cu/rf_we got %b/%b/%b exp 0/11/0", err_illegal, cu_state, rf_we); end
    step();
  endtask

  task automatic test_start_ignored();
    issue(16'h1600);
    start = 1'b1;
    instr = 16'hF0FF;
    step();
    checks++; if (rf_raddr_a !== 2'b01 || imm !== 8'h00 || alu_op !== 3'b000) begin
      errors++; $display("FAIL busy_start latched raddr_a/imm/alu_op got %b/%h/%b exp 01/00/000", rf_raddr_a, imm, alu_op); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 2'b01) begin errors++; $display("FAIL busy_start wb rf_we/waddr got %b/%b exp 1/01", rf_we, rf_waddr); end
    step();
    start = 1'b0;
    checks++; if (cu_state !== 2'b11 || halted !== 1'b0) begin errors++; $display("FAIL busy_start done cu/halted got %b/%b exp 11/0", cu_state, halted); end
    step();
    checks++; if (cu_state !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL busy_start idle cu/halted got %b/%b exp 00/0", cu_state, halted); end
  endtask

  task automatic test_reset_mid_mem();
    issue(16'h8123);
    step();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rst_mem pre req/we got %b/%b exp 1/1", mem_req, mem_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || cu_state !== 2'b00 || rf_we !== 1'b0 || pc_load !== 1'b0) begin
      errors++; $display("FAIL rst_mem immediate req/cu/rf_we/pc_load got %b/%b/%b/%b exp 0/00/0/0", mem_req, cu_state, rf_we, pc_load); end
    @(negedge clk) reset = 1'b0;
    step();
    step();
    checks++; if (cu_state !== 2'b00 || imm !== 8'h00 || rf_raddr_b !== 2'b00 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_mem after cu/imm/raddr_b/tout got %b/%h/%b/%b exp 00/00/00/0", cu_state, imm, rf_raddr_b, err_timeout); end
  endtask

  task automatic test_halt();
    int bad = 0;
    issue(16'hF000);
    step();
    checks++; if (halted !== 1'b1 || cu_state !== 2'b01) begin errors++; $display("FAIL halt_enter halted/cu got %b/%b exp 1/01", halted, cu_state); end
    start = 1'b1;
    instr = 16'h1600;
    for (int i = 0; i < 6; i++) begin
      step();
      if (halted !== 1'b1 || cu_state !== 2'b01 || rf_we !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_sticky bad cycles got %0d exp 0", bad); end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || cu_state !== 2'b00) begin errors++; $display("FAIL halt_reset halted/cu got %b/%b exp 0/00", halted, cu_state); end
    @(negedge clk) reset = 1'b0;
    step();
    issue(16'h0000);
    step();
    checks++; if (cu_state !== 2'b11 || rf_we !== 1'b0 || pc_load !== 1'b0) begin
      errors++; $display("FAIL nop_done_at_2 cu/rf_we/pc_load got %b/%b/%b exp 11/0/0", cu_state, rf_we, pc_load); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load();
    test_store_timeout();
    test_timeout_boundary();
    test_jumps();
    test_illegal();
    test_start_ignored();
    test_reset_mid_mem();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum MEM-state wait cycles before abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  instruction register holds a valid instruction; sampled only in IDLE.
REQ-005 instr  in  16  instruction: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-006 zero_flag  in  1  ALU zero flag, sampled in EXEC for JZ.
REQ-007 mem_ack  in  1  data memory completion, sampled in MEM.
REQ-008 cu_state  out  2  00 idle, 01 busy, 10 memory wait, 11 done.
REQ-009 rf_raddr_a / rf_raddr_b  out  2 each  register-file read addresses = latched rd / rs.
REQ-010 rf_waddr  out  2  write address = latched rd.
REQ-011 rf_we  out  1  register-file write strobe.
REQ-012 wb_sel  out  1  writeback source: 0 ALU result, 1 memory read data.
REQ-013 alu_op  out  3  ADD 000, SUB 001, AND 010, OR 011, XOR 100.
REQ-014 alu_src_imm  out  1  ALU operand B = imm instead of register rs.
REQ-015 imm  out  8  latched instr[7:0]: ALU immediate, memory address and jump target.
REQ-016 mem_req / mem_we  out  1 each  data memory request / write qualifier.
REQ-017 pc_load  out  1  one-cycle pulse: program counter loads imm.
REQ-018 halted / err_illegal / err_timeout  out  1 each  sticky halt; one-cycle error pulses.

Function
REQ-019 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI, 7 LOAD, 8 STORE, 9 JMP, A JZ, F HALT; B-E illegal.
REQ-020 States SHALL be IDLE, READ, EXEC, MEM, WB, DONE and HALTED; all outputs are Moore decodes of state plus the latched instruction.
REQ-021 IDLE (cu_state 00): when start=1, latch instr and go to READ; otherwise stay.
REQ-022 start asserted in any state other than IDLE SHALL be ignored, and the latched instruction SHALL be unchanged.
REQ-023 READ (cu_state 01, one cycle) SHALL transition as follows:
- ADD to ADDI, JMP, JZ: to EXEC.
- LOAD, STORE: to MEM.
- NOP: to DONE.
- HALT: to HALTED.
- Illegal opcode: pulse err_illegal and go to DONE.
REQ-024 EXEC (cu_state 01, one cycle) SHALL drive alu_op, with alu_src_imm=1 only for ADDI (ADDI uses ADD), then go to WB.
REQ-025 JMP in EXEC SHALL pulse pulse pc_load=1 and go to DONE.
REQ-026 JZ in EXEC SHALL pulse pc_load=zero_flag and go to DONE.
REQ-027 MEM (cu_state 10) SHALL hold mem_req=1, with mem_we=1 for STORE, until the cycle mem_ack=1.
REQ-028 On mem_ack in MEM: LOAD goes to WB with wb_sel=1; STORE goes to DONE.
REQ-029 A wait counter SHALL clear on MEM entry. If MEM_TIMEOUT cycles elapse without mem_ack, the block SHALL pulse err_timeout, drop mem_req, skip writeback and go to DONE.
REQ-030 mem_ack arriving in the same cycle as the timeout SHALL count as success.
REQ-031 WB (cu_state 01, one cycle) SHALL assert rf_we=1, then go to DONE.
REQ-032 DONE SHALL drive cu_state=11 for exactly one cycle, then return to IDLE; fixed latency start-to-DONE is:
- 2 cycles for NOP and illegal.
- 3 cycles for JMP and JZ.
- 4 cycles for ALU ops.
- 3+k cycles for STORE, 4+k cycles for LOAD, where k is the number of mem_ack wait cycles.
REQ-033 HALTED SHALL hold halted=1 and cu_state=01, and is left only by reset.
REQ-034 rf_we, mem_req, pc_load, err_illegal and err_timeout SHALL be 0 in every state not listed above.

Reset
REQ-035 reset SHALL force IDLE and clear the latched instruction, the wait counter, halted, and all strobes and pulses, with cu_state=00.
REQ-036 reset in mid-operation SHALL abandon the instruction with no rf_we and no pc_load; mem_req SHALL drop immediately.

Structure
REQ-037 A shared package cpu_pkg SHALL hold the opcode constants, alu_op codes, cu_state codes, state encoding and the MEM_TIMEOUT default.
REQ-038 A combinational sub-module exec_decode (opcode to instruction class, alu_op, alu_src_imm) SHALL be used; the state machine and timeout counter stay in exec_ctrl.

Verification
REQ-039 The bench SHALL cover the following directed scenarios:
- ADD: instr=0x1600 with start -> READ, EXEC (alu_op=000), WB (rf_we=1, rf_waddr=01), then cu_state=11 exactly 4 cycles after start.
- LOAD: instr=0x7442 with mem_ack after 3 cycles -> mem_req high 3 cycles, imm=0x42, WB with wb_sel=1, then DONE.
- STORE without mem_ack -> err_timeout pulses after 15 MEM cycles, no rf_we, DONE follows.
- JZ: instr=0xA010, once with zero_flag=1 and once with 0 -> pc_load=1 with imm=0x10 in the first case, and pc_load=0 in the second.
- Illegal 0xC000 -> err_illegal pulse then DONE. HALT 0xF000 -> halted stays 1, and later start pulses are ignored until reset.
- reset asserted during MEM -> mem_req=0 at once and cu_state=00; start during busy states has no effect.
